imap_rd_biu: RTL
================

// Module: imap_rd_biu
// PURPOSE
//  Input feature map read bus interface unit; read-side counterpart of the omap write BIU.
//  On start, issues IMAP_LEN word reads from imap_base_addr through the shared memory arbiter.
//  Returns the read data in order to the line buffer over a valid/ready stream.
//  A credit scheme bounds outstanding reads to free FIFO space, so no response is ever dropped.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  CNT_W       20  transfer length / counter width (words)
//  FIFO_DEPTH  8   response buffer depth, power of 2, >=2
// PORTS
//  clk                      in  1      clock
//  rst                      in  1      synchronous, active-high reset
//  start                    in  1      one-cycle start pulse
//  imap_base_addr           in  AW     word base address, sampled on accepted start
//  imap_len                 in  CNT_W  number of words, sampled on accepted start
//  busy                     out 1      transfer in progress
//  done                     out 1      one-cycle completion pulse
//  err                      out 1      sticky: unsolicited response seen; cleared by accepted start
//  imap_biu2arb_req         out 1      bus ownership request to arbiter
//  imap_biu2arb_addr        out AW     read address
//  imap_biu2arb_vld         out 1      read command valid
//  imap_biu2arb_rdy         in  1      read command ready
//  arb2imap_biu_data        in  DW     read response data
//  arb2imap_biu_vld         in  1      read response valid
//  arb2imap_biu_rdy         out 1      read response ready
//  imap_biu2lbuf_data       out DW     stream data to line buffer
//  imap_biu2lbuf_vld        out 1      stream valid
//  imap_biu2lbuf_rdy        in  1      stream ready
// BEHAVIOUR
//  Reset values: state=IDLE; req/vld/busy/done/err/lbuf_vld all 0; addr=0; rsp_rdy=1; FIFO empty; all counters 0.
//  FSM:
//   IDLE->ISSUE on start with len!=0 (latch base/len, clear err; req=1 and busy=1 next cycle).
//   IDLE->DONE on start with len==0 (no bus activity).
//   ISSUE->DRAIN when issue_cnt reaches len.
//   DRAIN->DONE when recv_cnt==len, FIFO empty, and no lbuf handshake pending.
//   DONE->IDLE unconditionally; done=1 only in DONE.
//  Start in any state other than IDLE is ignored.
//  Command issue:
//   - arb_vld = (state==ISSUE) & (issue_cnt<len) & (outstanding+fifo_cnt < FIFO_DEPTH).
//   - addr = base + zero-extended issue_cnt; wraps mod 2^AW.
//   - Once vld is high, vld and addr stay stable until rdy. Guaranteed because the credit
//     sum outstanding+fifo_cnt never rises without an issue handshake.
//   - Command handshake: issue_cnt++ and outstanding++.
//  Responses:
//   - rsp_rdy = !fifo_full.
//   - Handshake with outstanding>0: push into FIFO, outstanding--, recv_cnt++.
//   - Response with outstanding==0 (IDLE, or in flight across a reset): accepted, discarded, err=1.
//   - Same-cycle command and response handshakes: outstanding unchanged.
//  Request release: req falls the cycle after the response that makes recv_cnt==len.
//  Stream: show-ahead FIFO head drives lbuf_data/vld.
//   - Response accepted in cycle N -> lbuf_vld in cycle N+1 if FIFO was empty.
//   - Simultaneous push and pop keeps fifo_cnt.
//   - Order is strictly address order. Data is don't-care while vld=0.
//  Reset mid-operation: FSM, counters and FIFO flush to reset values next edge; no done pulse.
// STRUCTURE
//  Shared package acc_pkg: FSM state encodings (IDLE/ISSUE/DRAIN/DONE); AW/DW/CNT_W defaults.
//  Sub-module imap_rd_fifo: sync FIFO, params DW/DEPTH, show-ahead.
//   Ports: push/pop/full/empty/count; synchronous active-high reset clears pointers only.
//  Top: FSM, issue/recv/outstanding counters, credit compare.
// TESTING
//  1) base=0x1000, len=4, arb_rdy=1, rsp 2 cycles after each cmd, lbuf_rdy=1
//     -> addrs 0x1000..0x1003, data out in order, req low after 4th rsp, one done pulse.
//  2) len=20, lbuf_rdy=0 -> exactly 8 cmd handshakes then vld=0; lbuf_rdy=1
//     -> issue resumes, 20 words out, none lost.
//  3) arb_rdy held 0 for 5 cycles with vld=1 -> addr/vld unchanged all 5 cycles.
//  4) start with len=0 -> done 1 cycle later, req/vld never asserted.
//  5) start while busy -> ignored. rsp_vld in IDLE -> err=1, no lbuf_vld. Next start -> err=0.
//  6) rst after 3 of 10 words -> all outputs at reset values; then start len=2
//     -> 2 words, done, correct addresses.

Source files
------------

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared accelerator defaults and BIU state encoding
// Purpose: common widths and the read BIU FSM states, imported by the imap read BIU files.
// Ports: none (package).
package acc_pkg;

  localparam int AW_DEF    = 32;
  localparam int DW_DEF    = 32;
  localparam int CNT_W_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } biu_state_e;

endpackage

// File: rtl/imap_rd_biu_if.sv
// rtl/imap_rd_biu_if.sv - arbiter command/response and line-buffer stream bundle
// Purpose: groups the read BIU's bus-facing handshakes.
// Ports (master = BIU side):
//   imap_biu2arb_req/addr/vld out, imap_biu2arb_rdy in   : read command channel
//   arb2imap_biu_data/vld in, arb2imap_biu_rdy out       : read response channel
//   imap_biu2lbuf_data/vld out, imap_biu2lbuf_rdy in     : stream to line buffer
interface imap_rd_biu_if
  import acc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          imap_biu2arb_req;
  logic [AW-1:0] imap_biu2arb_addr;
  logic          imap_biu2arb_vld;
  logic          imap_biu2arb_rdy;
  logic [DW-1:0] arb2imap_biu_data;
  logic          arb2imap_biu_vld;
  logic          arb2imap_biu_rdy;
  logic [DW-1:0] imap_biu2lbuf_data;
  logic          imap_biu2lbuf_vld;
  logic          imap_biu2lbuf_rdy;

  modport master (
    output imap_biu2arb_req, imap_biu2arb_addr, imap_biu2arb_vld,
    input  imap_biu2arb_rdy,
    input  arb2imap_biu_data, arb2imap_biu_vld,
    output arb2imap_biu_rdy,
    output imap_biu2lbuf_data, imap_biu2lbuf_vld,
    input  imap_biu2lbuf_rdy
  );

  modport slave (
    input  imap_biu2arb_req, imap_biu2arb_addr, imap_biu2arb_vld,
    output imap_biu2arb_rdy,
    output arb2imap_biu_data, arb2imap_biu_vld,
    input  arb2imap_biu_rdy,
    input  imap_biu2lbuf_data, imap_biu2lbuf_vld,
    output imap_biu2lbuf_rdy
  );

endinterface

// File: rtl/imap_rd_fifo.sv
// rtl/imap_rd_fifo.sv - show-ahead synchronous response FIFO
// Purpose: buffers read responses; the head word is visible on rdata whenever !empty.
// Ports: clk, rst (sync active-high, clears pointers/count only),
//        push/wdata/full (write side), pop/rdata/empty (read side), count (occupancy).
module imap_rd_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  output logic                     full,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/imap_rd_biu.sv
// rtl/imap_rd_biu.sv - input feature map read bus interface unit
// Purpose: on start, reads imap_len words from imap_base_addr through the arbiter and
//          streams them in address order to the line buffer; outstanding reads are
//          limited by free response FIFO space so no response is ever dropped.
// Ports: clk, rst (sync active-high), start, imap_base_addr, imap_len (sampled on
//        accepted start), busy, done (1-cycle pulse), err (sticky unsolicited response),
//        bus (imap_rd_biu_if.master: arbiter command/response + line buffer stream).
module imap_rd_biu
  import acc_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    imap_base_addr,
  input  logic [CNT_W-1:0] imap_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  imap_rd_biu_if.master    bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  biu_state_e       state_q, state_d;
  logic [AW-1:0]    base_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic [CNT_W-1:0] recv_nxt;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    fifo_cnt;
  logic [CW:0]      credit_sum;
  logic             req_q;
  logic             err_q;
  logic             cmd_vld;
  logic             start_acc;
  logic             cmd_hs;
  logic             rsp_hs;
  logic             rsp_ok;
  logic             rsp_bad;
  logic             fifo_full;
  logic             fifo_empty;
  logic             lbuf_pop;

  assign start_acc  = start & (state_q == ST_IDLE);
  assign cmd_hs     = cmd_vld & bus.imap_biu2arb_rdy;
  assign rsp_hs     = bus.arb2imap_biu_vld & bus.arb2imap_biu_rdy;
  // A response with nothing outstanding is still accepted so the bus never stalls on it.
  assign rsp_ok     = rsp_hs & (outstanding != '0);
  assign rsp_bad    = rsp_hs & (outstanding == '0);
  assign recv_nxt   = recv_cnt + 1'b1;
  assign lbuf_pop   = bus.imap_biu2lbuf_vld & bus.imap_biu2lbuf_rdy;
  // Reserved FIFO slots: in-flight reads plus words already buffered.
  assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_cnt};

  always_comb begin
    state_d = state_q;
    cmd_vld = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (imap_len == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        busy    = 1'b1;
        cmd_vld = (issue_cnt < len_q) && (credit_sum < (CW+1)'(FIFO_DEPTH));
        if (issue_cnt == len_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if ((recv_cnt == len_q) && fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      outstanding <= '0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        base_q    <= imap_base_addr;
        len_q     <= imap_len;
        issue_cnt <= '0;
        recv_cnt  <= '0;
        req_q     <= (imap_len != '0);
      end else begin
        if (cmd_hs) issue_cnt <= issue_cnt + 1'b1;
        if (rsp_ok) begin
          recv_cnt <= recv_nxt;
          if (recv_nxt == len_q) req_q <= 1'b0;
        end
      end
      case ({cmd_hs, rsp_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (rsp_bad)        err_q <= 1'b1;
      else if (start_acc) err_q <= 1'b0;
    end
  end

  assign err                   = err_q;
  assign bus.imap_biu2arb_req  = req_q;
  assign bus.imap_biu2arb_vld  = cmd_vld;
  assign bus.imap_biu2arb_addr = base_q + AW'(issue_cnt);
  assign bus.arb2imap_biu_rdy  = ~fifo_full;
  assign bus.imap_biu2lbuf_vld = ~fifo_empty;

  imap_rd_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_ok),
    .wdata (bus.arb2imap_biu_data),
    .full  (fifo_full),
    .pop   (lbuf_pop),
    .rdata (bus.imap_biu2lbuf_data),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule
